// File: rtl/heater_sched.sv
// Ramps a thermometer-coded bank of ring-oscillator heaters toward a commanded level,
// one ring per step. Optional running-feedback watchdog: define HEATER_WATCHDOG_EN.
module heater_sched #(
  parameter int NUM_RINGS   = 16,
  parameter int LEVEL_W     = 5,
  parameter int STEP_CYCLES = 256,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEVEL_W-1:0]   cmd_level,
  output logic [NUM_RINGS-1:0] ring_enable,
  input  logic [NUM_RINGS-1:0] ring_running,
  output logic [LEVEL_W-1:0]   active_count,
  output logic                 busy,
  output logic                 fault
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] RAMP_UP   = 2'd1;
  localparam logic [1:0] RAMP_DOWN = 2'd2;
  localparam logic [1:0] FAULT     = 2'd3;

  localparam int TW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]      STEP_RELOAD = TW'(STEP_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] MAX_LEVEL   = LEVEL_W'(NUM_RINGS);

  function automatic logic [NUM_RINGS-1:0] thermo(input logic [LEVEL_W-1:0] n);
    logic [NUM_RINGS-1:0] t;
    for (int i = 0; i < NUM_RINGS; i++) t[i] = (LEVEL_W'(i) < n);
    return t;
  endfunction

  function automatic logic [1:0] dir_of(input logic [LEVEL_W-1:0] tgt, input logic [LEVEL_W-1:0] cnt);
    if (tgt > cnt)      return RAMP_UP;
    else if (tgt < cnt) return RAMP_DOWN;
    else                return IDLE;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [LEVEL_W-1:0]   count_q, count_d;
  logic [LEVEL_W-1:0]   target_q, target_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 pending_q, pending_d;
  logic [NUM_RINGS-1:0] enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;
  logic                 accept_s;

`ifdef HEATER_WATCHDOG_EN
  localparam int WW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_RELOAD = WW'(WDOG_CYCLES - 1);
  logic [WW-1:0] wdog_q, wdog_d;
`else
  logic unused_running_s;
  assign unused_running_s = ^ring_running;
`endif

  // Next-state: command capture, ramp stepping and optional watchdog trip.
  always_comb begin
    accept_s  = cmd_valid && ready_q;
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    timer_d   = timer_q;
    pending_d = 1'b0;
    if (accept_s) begin
      target_d  = (cmd_level > MAX_LEVEL) ? MAX_LEVEL : cmd_level;
      pending_d = 1'b1;
    end else begin
      target_d  = target_q;
    end
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d = dir_of(target_q, count_q);
          timer_d = (state_d != IDLE) ? STEP_RELOAD : {TW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        // Direction follows the live target, so a retarget reverses without reloading the timer.
        if (timer_q == {TW{1'b0}}) begin
          timer_d = STEP_RELOAD;
          if (target_q > count_q)      count_d = count_q + LEVEL_W'(1);
          else if (target_q < count_q) count_d = count_q - LEVEL_W'(1);
          else                         count_d = count_q;
        end else begin
          timer_d = timer_q - TW'(1);
        end
        state_d = dir_of(target_q, count_d);
        if (state_d == IDLE) timer_d = {TW{1'b0}};
        else                 timer_d = timer_d;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    enable_d = thermo(count_d);
`ifdef HEATER_WATCHDOG_EN
    if (state_q != FAULT && wdog_q == {WW{1'b0}} &&
        ((ring_running & enable_q) != enable_q)) begin
      state_d   = FAULT;
      count_d   = {LEVEL_W{1'b0}};
      timer_d   = {TW{1'b0}};
      pending_d = 1'b0;
      enable_d  = {NUM_RINGS{1'b0}};
    end else begin
      state_d   = state_d;
    end
    if (enable_d != enable_q)        wdog_d = WDOG_RELOAD;
    else if (wdog_q == {WW{1'b0}})   wdog_d = {WW{1'b0}};
    else                             wdog_d = wdog_q - WW'(1);
`endif
    busy_d  = (state_d != IDLE);
    ready_d = (state_d != FAULT);
    fault_d = (state_d == FAULT);
  end

  // State and registered outputs; reset drops every ring at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= {LEVEL_W{1'b0}};
      target_q  <= {LEVEL_W{1'b0}};
      timer_q   <= {TW{1'b0}};
      pending_q <= 1'b0;
      enable_q  <= {NUM_RINGS{1'b0}};
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
`ifdef HEATER_WATCHDOG_EN
      wdog_q    <= {WW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
`ifdef HEATER_WATCHDOG_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  assign cmd_ready    = ready_q;
  assign ring_enable  = enable_q;
  assign active_count = count_q;
  assign busy         = busy_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_heater_sched.sv
// Directed bench for heater_sched with NUM_RINGS=4, STEP_CYCLES=4, WDOG_CYCLES=8.
module tb_heater_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_level;
  logic [3:0] ring_enable;
  logic [3:0] ring_running;
  logic [2:0] active_count;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  heater_sched #(.NUM_RINGS(4), .LEVEL_W(3), .STEP_CYCLES(4), .WDOG_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_level(cmd_level), .ring_enable(ring_enable), .ring_running(ring_running),
    .active_count(active_count), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] therm4(input int n);
    logic [3:0] t;
    for (int j = 0; j < 4; j++) t[j] = (j < n);
    return t;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; cmd_valid = 1'b0; tick;
    rst = 1'b0; tick;
  endtask

  task automatic send(input logic [2:0] lvl);
    cmd_valid = 1'b1; cmd_level = lvl; tick;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b1; cmd_level = 3'd3; tick;
    checks++; if (active_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", active_count); end
    checks++; if (ring_enable !== 4'b0000) begin errors++; $display("FAIL rst_enable got %b exp 0000", ring_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", cmd_ready); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %b exp 0", fault); end
    cmd_valid = 1'b0; rst = 1'b0; tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", cmd_ready); end
  endtask

  task automatic test_ramp_up;
    int exp_cnt;
    do_reset;
    send(3'd3);
    for (int e = 1; e <= 15; e++) begin
      tick;
      exp_cnt = (e >= 13) ? 3 : (e >= 9) ? 2 : (e >= 5) ? 1 : 0;
      checks++; if (active_count !== 3'(exp_cnt)) begin errors++; $display("FAIL ramp_count e%0d got %0d exp %0d", e, active_count, exp_cnt); end
      checks++; if (ring_enable !== therm4(exp_cnt)) begin errors++; $display("FAIL ramp_enable e%0d got %b exp %b", e, ring_enable, therm4(exp_cnt)); end
      checks++; if (busy !== (e < 13)) begin errors++; $display("FAIL ramp_busy e%0d got %b exp %b", e, busy, (e < 13)); end
    end
  endtask

  task automatic test_saturate;
    int exp_cnt;
    do_reset;
    send(3'd7);
    for (int e = 1; e <= 20; e++) begin
      tick;
      exp_cnt = (e >= 17) ? 4 : (e >= 13) ? 3 : (e >= 9) ? 2 : (e >= 5) ? 1 : 0;
      checks++; if (active_count !== 3'(exp_cnt)) begin errors++; $display("FAIL sat_count e%0d got %0d exp %0d", e, active_count, exp_cnt); end
      checks++; if (busy !== (e < 17)) begin errors++; $display("FAIL sat_busy e%0d got %b exp %b", e, busy, (e < 17)); end
    end
    checks++; if (ring_enable !== 4'b1111) begin errors++; $display("FAIL sat_enable got %b exp 1111", ring_enable); end
  endtask

  task automatic test_retarget;
    do_reset;
    send(3'd4);
    repeat (13) tick;
    checks++; if (active_count !== 3'd3) begin errors++; $display("FAIL rt_pre got %0d exp 3", active_count); end
    send(3'd1);
    tick;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rt_busy1 got %b exp 1", busy); end
    tick;
    checks++; if (active_count !== 3'd3) begin errors++; $display("FAIL rt_hold got %0d exp 3", active_count); end
    tick;
    checks++; if (active_count !== 3'd2) begin errors++; $display("FAIL rt_down1 got %0d exp 2", active_count); end
    checks++; if (ring_enable !== 4'b0011) begin errors++; $display("FAIL rt_en2 got %b exp 0011", ring_enable); end
    repeat (3) tick;
    checks++; if (active_count !== 3'd2) begin errors++; $display("FAIL rt_hold2 got %0d exp 2", active_count); end
    tick;
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL rt_down2 got %0d exp 1", active_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rt_idle got %b exp 0", busy); end
    repeat (5) tick;
    checks++; if (ring_enable !== 4'b0001) begin errors++; $display("FAIL rt_final got %b exp 0001", ring_enable); end
  endtask

  task automatic test_equal_target;
    do_reset;
    send(3'd0);
    for (int e = 1; e <= 6; e++) begin
      tick;
      checks++; if (busy !== 1'b0 || ring_enable !== 4'b0000) begin errors++; $display("FAIL eq_idle e%0d got busy %b en %b exp 0 0000", e, busy, ring_enable); end
    end
    send(3'd3);
    repeat (5) tick;
    send(3'd1);
    tick;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL eq_mid_busy got %b exp 0", busy); end
    repeat (8) tick;
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL eq_mid_count got %0d exp 1", active_count); end
    checks++; if (ring_enable !== 4'b0001) begin errors++; $display("FAIL eq_mid_en got %b exp 0001", ring_enable); end
  endtask

  task automatic test_same_edge;
    do_reset;
    send(3'd2);
    repeat (4) tick;
    send(3'd0);
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL se_step got %0d exp 1", active_count); end
    tick;
    checks++; if (active_count !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL se_eval got cnt %0d busy %b exp 1 1", active_count, busy); end
    repeat (2) tick;
    checks++; if (active_count !== 3'd1) begin errors++; $display("FAIL se_hold got %0d exp 1", active_count); end
    tick;
    checks++; if (active_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL se_done got cnt %0d busy %b exp 0 0", active_count, busy); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    send(3'd4);
    repeat (9) tick;
    checks++; if (ring_enable !== 4'b0011) begin errors++; $display("FAIL rm_pre got %b exp 0011", ring_enable); end
    rst = 1'b1; tick;
    checks++; if (ring_enable !== 4'b0000 || active_count !== 3'd0) begin errors++; $display("FAIL rm_drop got en %b cnt %0d exp 0000 0", ring_enable, active_count); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rm_flags got busy %b ready %b exp 0 0", busy, cmd_ready); end
    rst = 1'b0; tick;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", cmd_ready); end
    repeat (6) tick;
    checks++; if (active_count !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rm_stay got cnt %0d busy %b exp 0 0", active_count, busy); end
  endtask

  task automatic test_watchdog;
    ring_running = 4'b0001;
    do_reset;
    send(3'd2);
    repeat (9) tick;
    checks++; if (ring_enable !== 4'b0011) begin errors++; $display("FAIL wd_pre got %b exp 0011", ring_enable); end
    repeat (7) tick;
    checks++; if (fault !== 1'b0 || ring_enable !== 4'b0011) begin errors++; $display("FAIL wd_window got fault %b en %b exp 0 0011", fault, ring_enable); end
    tick;
`ifdef HEATER_WATCHDOG_EN
    checks++; if (fault !== 1'b1 || ring_enable !== 4'b0000) begin errors++; $display("FAIL wd_trip got fault %b en %b exp 1 0000", fault, ring_enable); end
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1 || active_count !== 3'd0) begin errors++; $display("FAIL wd_flags got ready %b busy %b cnt %0d exp 0 1 0", cmd_ready, busy, active_count); end
    cmd_valid = 1'b1; cmd_level = 3'd4;
    repeat (10) tick;
    cmd_valid = 1'b0;
    checks++; if (fault !== 1'b1 || ring_enable !== 4'b0000) begin errors++; $display("FAIL wd_sticky got fault %b en %b exp 1 0000", fault, ring_enable); end
`else
    checks++; if (fault !== 1'b0 || ring_enable !== 4'b0011) begin errors++; $display("FAIL wd_off got fault %b en %b exp 0 0011", fault, ring_enable); end
    repeat (10) tick;
    checks++; if (fault !== 1'b0 || ring_enable !== 4'b0011 || busy !== 1'b0) begin errors++; $display("FAIL wd_off_hold got fault %b en %b busy %b exp 0 0011 0", fault, ring_enable, busy); end
`endif
    ring_running = 4'b1111;
    do_reset;
    checks++; if (fault !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wd_clear got fault %b ready %b exp 0 1", fault, cmd_ready); end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_level = 3'd0; ring_running = 4'b1111;
    #1;
    test_reset;
    test_ramp_up;
    test_saturate;
    test_retarget;
    test_equal_target;
    test_same_edge;
    test_reset_mid;
    test_watchdog;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
